// File: rtl/fft_stage5_twiddle_rotator_pkg.sv
// Shared constants, payload types and the round/saturate helper used by the FFT stage rotators.
package fft_stage5_twiddle_rotator_pkg;

  localparam int unsigned N         = 256;
  localparam int unsigned SIZE      = $clog2(N);
  localparam int unsigned BW        = 16;
  localparam int unsigned BW_TW     = 14;
  localparam int unsigned ADDR_W    = SIZE - 5;
  localparam int unsigned TW_FRAC   = 12;
  localparam int unsigned TW_ONE    = 4096;
  localparam int unsigned BLK_SIZE  = 16;
  localparam int unsigned CNT_W     = $clog2(BLK_SIZE);
  localparam int unsigned HALF_BIT  = 3;
  localparam int unsigned PROD_W    = BW + BW_TW;
  localparam int unsigned SUM_W     = PROD_W + 1;

  typedef struct packed {
    logic signed [BW-1:0] re;
    logic signed [BW-1:0] im;
  } cplx_t;

  // Round half up at bit 'frac', then clamp into a signed 'width'-bit range.
  function automatic logic signed [31:0] sat_round(input logic signed [63:0] x,
                                                   input int unsigned frac,
                                                   input int unsigned width);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (x + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return 32'(r);
  endfunction

endpackage

// File: rtl/fft_stage5_twiddle_rotator_complex_mult_q12.sv
// Two-cycle complex multiply by a Q1.12 twiddle: registered products, then sum/round/saturate.
module complex_mult_q12
  import fft_stage5_twiddle_rotator_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [BW-1:0]    in_a,
  input  logic signed [BW-1:0]    in_b,
  input  logic signed [BW_TW-1:0] tw_c,
  input  logic signed [BW_TW-1:0] tw_d,
  output logic                    out_valid,
  output logic signed [BW-1:0]    out_re,
  output logic signed [BW-1:0]    out_im
);

  logic signed [PROD_W-1:0] ac_d, bd_d, ad_d, bc_d;
  logic signed [PROD_W-1:0] ac_q, bd_q, ad_q, bc_q;
  logic                     p2_valid_d, p2_valid_q;
  logic signed [SUM_W-1:0]  sum_re, sum_im;
  logic signed [BW-1:0]     re_d, re_q, im_d, im_q;
  logic                     p3_valid_d, p3_valid_q;

  always_comb begin
    ac_d       = ac_q;
    bd_d       = bd_q;
    ad_d       = ad_q;
    bc_d       = bc_q;
    p2_valid_d = in_valid;
    if (in_valid) begin
      ac_d = PROD_W'(in_a) * PROD_W'(tw_c);
      bd_d = PROD_W'(in_b) * PROD_W'(tw_d);
      ad_d = PROD_W'(in_a) * PROD_W'(tw_d);
      bc_d = PROD_W'(in_b) * PROD_W'(tw_c);
    end
  end

  // Output registers only move on a valid P3 sample; otherwise they hold.
  always_comb begin
    sum_re     = SUM_W'(ac_q) - SUM_W'(bd_q);
    sum_im     = SUM_W'(ad_q) + SUM_W'(bc_q);
    re_d       = re_q;
    im_d       = im_q;
    p3_valid_d = p2_valid_q;
    if (p2_valid_q) begin
      re_d = BW'(sat_round(64'(sum_re), TW_FRAC, BW));
      im_d = BW'(sat_round(64'(sum_im), TW_FRAC, BW));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_q       <= '0;
      bd_q       <= '0;
      ad_q       <= '0;
      bc_q       <= '0;
      p2_valid_q <= 1'b0;
      re_q       <= '0;
      im_q       <= '0;
      p3_valid_q <= 1'b0;
    end else begin
      ac_q       <= ac_d;
      bd_q       <= bd_d;
      ad_q       <= ad_d;
      bc_q       <= bc_d;
      p2_valid_q <= p2_valid_d;
      re_q       <= re_d;
      im_q       <= im_d;
      p3_valid_q <= p3_valid_d;
    end
  end

  assign out_valid = p3_valid_q;
  assign out_re    = re_q;
  assign out_im    = im_q;

endmodule

// File: rtl/fft_stage5_twiddle_rotator.sv
// Stage-5 SDF twiddle rotator: block index counter, ROM read issue, P1 alignment, complex multiply.
module fft_stage5_twiddle_rotator
  import fft_stage5_twiddle_rotator_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_start,
  input  logic signed [BW-1:0]    in_re,
  input  logic signed [BW-1:0]    in_im,
  output logic                    rom_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic signed [BW_TW-1:0] rom_cos,
  input  logic signed [BW_TW-1:0] rom_sin,
  output logic                    out_valid,
  output logic signed [BW-1:0]    out_re,
  output logic signed [BW-1:0]    out_im
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] idx;
  logic             p1_valid_d, p1_valid_q;
  cplx_t            p1_d, p1_q;

  // Upper-half samples read entry 0 (W=1); lower-half samples read their angle.
  always_comb begin
    idx      = in_start ? '0 : cnt_q;
    rom_addr = idx[HALF_BIT] ? idx[ADDR_W-1:0] : '0;
    rom_en   = in_valid;
    cnt_d    = cnt_q;
    if (in_valid) begin
      cnt_d = in_start ? CNT_W'(1) : cnt_q + CNT_W'(1);
    end
  end

  // P1 holds the sample while the registered ROM read completes.
  always_comb begin
    p1_valid_d = in_valid;
    p1_d       = p1_q;
    if (in_valid) begin
      p1_d.re = in_re;
      p1_d.im = in_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      p1_valid_q <= 1'b0;
      p1_q       <= '0;
    end else begin
      cnt_q      <= cnt_d;
      p1_valid_q <= p1_valid_d;
      p1_q       <= p1_d;
    end
  end

  complex_mult_q12 u_cmult (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (p1_valid_q),
    .in_a      (p1_q.re),
    .in_b      (p1_q.im),
    .tw_c      (rom_cos),
    .tw_d      (rom_sin),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im)
  );

endmodule

// File: tb/tb_fft_stage5_twiddle_rotator.sv
// Scoreboard bench for the stage-5 twiddle rotator with a behavioural W16 twiddle ROM.
module tb_fft_stage5_twiddle_rotator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_start;
  logic signed [15:0] in_re;
  logic signed [15:0] in_im;
  logic               rom_en;
  logic [2:0]         rom_addr;
  logic signed [13:0] rom_cos = '0;
  logic signed [13:0] rom_sin = '0;
  logic               out_valid;
  logic signed [15:0] out_re;
  logic signed [15:0] out_im;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad   = 0;
  logic [2:0] vhist;

  int cos_tab[8] = '{4096, 3784, 2896, 1567, 0, -1567, -2896, -3784};
  int sin_tab[8] = '{0, -1567, -2896, -3784, -4096, -3784, -2896, -1567};

  fft_stage5_twiddle_rotator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_start  (in_start),
    .in_re     (in_re),
    .in_im     (in_im),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_cos   (rom_cos),
    .rom_sin   (rom_sin),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im)
  );

  always #5 clk = ~clk;

  // Registered-read twiddle ROM, W16^k with the -sin convention.
  always @(posedge clk) begin
    if (rom_en) begin
      rom_cos <= 14'(cos_tab[rom_addr]);
      rom_sin <= 14'(sin_tab[rom_addr]);
    end
  end

  // Accepted-input history; out_valid must equal the bit from three cycles back.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) vhist <= 3'b000;
    else        vhist <= {vhist[1:0], in_valid};
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if (out_valid !== vhist[2]) begin
        bad++;
        $display("FAIL out_valid_timing: got %b want %b at %0t", out_valid, vhist[2], $time);
      end
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got (%0d,%0d) want no output at %0t", out_re, out_im, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          total++;
          if (out_re !== e.re || out_im !== e.im) begin
            bad++;
            $display("FAIL sample: got (%0d,%0d) want (%0d,%0d) at %0t",
                     out_re, out_im, e.re, e.im, $time);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Drive one cycle; check the ROM request and queue the expected output for valid samples.
  task automatic send(input logic v, input logic s, input int re, input int im,
                      input int addr, input int ere, input int eim);
    exp_t e;
    in_valid = v;
    in_start = s;
    in_re    = 16'(re);
    in_im    = 16'(im);
    #1;
    total++;
    if (v) begin
      if (rom_en !== 1'b1 || rom_addr !== 3'(addr)) begin
        bad++;
        $display("FAIL rom_req: got en=%b addr=%0d want en=1 addr=%0d", rom_en, rom_addr, addr);
      end
      e.re = 16'(ere);
      e.im = 16'(eim);
      q.push_back(e);
    end else if (rom_en !== 1'b0) begin
      bad++;
      $display("FAIL rom_en_idle: got %b want 0", rom_en);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    send(1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_re    = '0;
    in_im    = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Mid-stream reset: outputs clear at once, in-flight samples dropped.
    send(1'b1, 1'b1, 11, 22, 0, 11, 22);
    send(1'b1, 1'b0, 33, 44, 0, 33, 44);
    send(1'b1, 1'b0, 55, 66, 0, 55, 66);
    send(1'b1, 1'b0, 77, 88, 0, 77, 88);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_re", int'(out_re), 0);
    chk("rst_out_im", int'(out_im), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Counter restarts from 0 after reset: the tenth sample is index 9 -> addr 1.
    for (int i = 0; i < 9; i++) send(1'b1, 1'b0, 100, 200, 0, 100, 200);
    send(1'b1, 1'b0, 1000, 0, 1, 924, -383);

    // Full block: unity upper half, then hand-computed lower-half rotations.
    for (int i = 0; i < 8; i++) send(1'b1, (i == 0), 1000, -500, 0, 1000, -500);
    send(1'b1, 1'b0, -1234, 567, 0, -1234, 567);
    send(1'b1, 1'b0, 0, 0, 1, 0, 0);
    send(1'b1, 1'b0, 1000, 0, 2, 707, -707);
    send(1'b1, 1'b0, 0, 0, 3, 0, 0);
    send(1'b1, 1'b0, 1000, 0, 4, 0, -1000);
    send(1'b1, 1'b0, 0, 0, 5, 0, 0);
    send(1'b1, 1'b0, 32767, 32767, 6, 0, -32768);
    send(1'b1, 1'b0, 0, 0, 7, 0, 0);

    // Wrapped block with gaps, then a start at index 5 restarts the index.
    send(1'b1, 1'b0, 1, 2, 0, 1, 2);
    gap();
    send(1'b1, 1'b0, 3, 4, 0, 3, 4);
    send(1'b1, 1'b0, 5, 6, 0, 5, 6);
    gap();
    gap();
    send(1'b1, 1'b0, 7, 8, 0, 7, 8);
    gap();
    send(1'b1, 1'b0, 9, 10, 0, 9, 10);
    send(1'b1, 1'b1, 11, 12, 0, 11, 12);
    for (int j = 1; j < 8; j++) begin
      send(1'b1, 1'b0, 100 + j, -j, 0, 100 + j, -j);
      if ($urandom_range(1, 0) == 1) gap();
    end
    send(1'b1, 1'b0, 1000, 0, 0, 1000, 0);
    gap();
    send(1'b1, 1'b0, 1000, 0, 1, 924, -383);
    send(1'b1, 1'b0, 1000, 0, 2, 707, -707);
    gap();
    send(1'b1, 1'b0, 0, 1000, 3, 924, 383);

    repeat (6) gap();
    chk("scoreboard_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
